// File: rtl/key_pkg.sv
// key_pkg: shared FSM state encoding and default hold timings for key_event.
package key_pkg;
    typedef logic [1:0] key_state_t;
    localparam key_state_t ST_IDLE = 2'd0;
    localparam key_state_t ST_HOLD = 2'd1;
    localparam key_state_t ST_LONG = 2'd2;
    localparam int KEY_LONG_CYCLES_DEF = 50_000_000;
    localparam int KEY_REPEAT_CYCLES_DEF = 10_000_000;
endpackage

// File: rtl/key_event.sv
// key_event: turns a debounced key level into press/release/long/repeat pulses.
// Define KEY_AUTOREPEAT_EN to enable periodic repeat_pulse while held after a long press.
module key_event
    import key_pkg::*;
#(
    parameter int LONG_CYCLES = KEY_LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = KEY_REPEAT_CYCLES_DEF,
    parameter int CNT_W = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_stable,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);
    if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2 || (LONG_CYCLES >> CNT_W) != 0 || (REPEAT_CYCLES >> CNT_W) != 0) begin : g_bad_cfg
        $error("key_event: invalid LONG_CYCLES/REPEAT_CYCLES/CNT_W");
    end
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    logic key_prev;
    logic [CNT_W-1:0] cnt;
    key_state_t state;
    logic idle, rise, fall, long_hit, rep_hit, cnt_run;
    assign idle = state == ST_IDLE;
    assign rise = key_stable & ~key_prev;
    assign fall = ~key_stable & key_prev;
    assign long_hit = (state == ST_HOLD) && (cnt == LONG_LAST);
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    assign rep_hit = (state == ST_LONG) && (cnt == REP_LAST);
    assign cnt_run = !idle;
`else
    assign rep_hit = 1'b0;
    assign cnt_run = state == ST_HOLD;
`endif
    // A release edge suppresses any terminal-count pulse in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_prev      <= 1'b0;
            cnt           <= '0;
            state         <= ST_IDLE;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            key_prev      <= key_stable;
            press_pulse   <= idle && rise;
            release_pulse <= !idle && fall;
            long_pulse    <= long_hit && !fall;
            repeat_pulse  <= rep_hit && !fall;
            held          <= idle ? rise : !fall;
            state         <= idle ? (rise ? ST_HOLD : ST_IDLE) : fall ? ST_IDLE : long_hit ? ST_LONG : state;
            cnt           <= (idle || fall || long_hit || rep_hit) ? '0 : cnt_run ? cnt + 1'b1 : cnt;
        end
    end
endmodule

// File: tb/tb_key_event.sv
// tb_key_event: scoreboard bench for key_event with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_key_event;
    localparam int L = 8;
    localparam int R = 4;
    typedef struct {
        int cyc;
        logic [3:0] p;
    } ev_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_stable = 1'b1;
    logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;
    logic [3:0] pulses;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int held_lo = 0;
    int held_hi = 0;
    ev_t q[$];
    key_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .CNT_W(5)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_stable(key_stable),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse),
        .held(held)
    );
    assign pulses = {press_pulse, release_pulse, long_pulse, repeat_pulse};
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask
    task automatic push_ev(input int c, input logic [3:0] p);
        ev_t e;
        e.cyc = c;
        e.p = p;
        q.push_back(e);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // pulses encoded {press, release, long, repeat}
    task automatic run_hold(input int h);
        int n;
        n = cyc + 1;
        push_ev(n, 4'b1000);
        if (h > L) push_ev(n + L, 4'b0010);
`ifdef KEY_AUTOREPEAT_EN
        for (int t = n + L + R; t < n + h; t += R) push_ev(t, 4'b0001);
`endif
        push_ev(n + h, 4'b0100);
        held_lo = n;
        held_hi = n + h;
        key_stable = 1'b1;
        repeat (h) tick();
        key_stable = 1'b0;
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                check("pulse", {28'd0, pulses}, {28'd0, q[0].p});
                void'(q.pop_front());
            end else begin
                check("quiet", {28'd0, pulses}, 32'd0);
            end
            check("held", {31'd0, held}, {31'd0, cyc >= held_lo && cyc < held_hi});
        end
    end
    initial begin
        int n;
        repeat (3) tick();
        check("rst_out", {27'd0, pulses, held}, 32'd0);
        rst_n = 1'b1;
        run_hold(3);
        repeat (3) tick();
        run_hold(1);
        repeat (2) tick();
        run_hold(20);
        repeat (3) tick();
        run_hold(L);
        repeat (2) tick();
        run_hold(L + 1);
        repeat (2) tick();
        n = cyc + 1;
        push_ev(n, 4'b1000);
        push_ev(n + L, 4'b0010);
        held_lo = n;
        held_hi = 1 << 30;
        key_stable = 1'b1;
        repeat (L + 2) tick();
        check("pre_rst_held", {31'd0, held}, 32'd1);
        rst_n = 1'b0;
        q.delete();
        held_hi = 0;
        #1;
        check("rst_mid", {27'd0, pulses, held}, 32'd0);
        tick();
        tick();
        check("rst_hold", {27'd0, pulses, held}, 32'd0);
        rst_n = 1'b1;
        run_hold(12);
        repeat (4) tick();
        check("drain", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_event.md
# key_event

Converts the debounced, active-high key level from the debounce stage into single-cycle event pulses: press, release, long-press, and (optionally) auto-repeat. It sits directly downstream of the debouncer, one instance per key. Its pulses feed the project's control FSMs, so no consumer has to do its own edge detection or hold timing.

## Interface
- `LONG_CYCLES`, default 50_000_000: number of cycles the key must stay held after `press_pulse` before `long_pulse` fires; must be ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: period of `repeat_pulse` while held after the long-press; must be ≥ 2.
- `CNT_W`, default 26: hold-counter width; must satisfy 2^CNT_W > max(`LONG_CYCLES`, `REPEAT_CYCLES`).
- `clk`, input, 1: the single system clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `key_stable`, input, 1: debounced key level, 1 = pressed, already synchronous to `clk`.
- `press_pulse`, output, 1: one-cycle pulse on a press.
- `release_pulse`, output, 1: one-cycle pulse on a release.
- `long_pulse`, output, 1: one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeat_pulse`, output, 1: one-cycle pulse every `REPEAT_CYCLES` after `long_pulse`.
- `held`, output, 1: registered level, 1 from `press_pulse` through the cycle before `release_pulse`.

## Operation
- Internal state:
  - `key_prev` register, used for edge detection.
  - `CNT_W`-bit hold counter `cnt`.
  - FSM with states IDLE, HOLD, LONG.
- All outputs are registered. Reset value of every output is 0, `key_prev` = 0, `cnt` = 0, state = IDLE.
- **IDLE:** when `key_stable`=1 and `key_prev`=0:
  - go to HOLD;
  - `cnt` ← 0;
  - `press_pulse` = 1 for the next cycle;
  - `held` ← 1.
- **HOLD:** `cnt` increments every cycle.
  - When `cnt` = `LONG_CYCLES`−1: go to LONG, `long_pulse` = 1 for one cycle, `cnt` ← 0.
- **LONG:**
  - With `KEY_AUTOREPEAT_EN`: `cnt` increments; when `cnt` = `REPEAT_CYCLES`−1, `repeat_pulse` = 1 for one cycle and `cnt` ← 0.
  - Without it: `cnt` holds at 0.
- **Release:** in HOLD or LONG, when `key_stable`=0 and `key_prev`=1:
  - go to IDLE;
  - `release_pulse` = 1 for one cycle;
  - `held` ← 0;
  - `cnt` ← 0.
- **Priority:** release beats long/repeat in the same cycle. If the release edge coincides with a terminal count, only `release_pulse` fires.
- **Counter range:** `cnt` never wraps. It is cleared at every terminal count and on release.
- **Mutual exclusion:** at most one of the four pulse outputs is high in any cycle.
- **Reset mid-operation:** all state clears immediately and no pulse is emitted.
  - If the key is still held when `rst_n` deasserts, `key_prev`=0 makes that hold a fresh press: `press_pulse` fires on the first active edge where `key_stable`=1.

## Timing
- **Latency:** `key_stable` edge sampled at clock edge N produces the corresponding pulse high during cycle N+1 (one-cycle latency).
- **Long-press timing:** `long_pulse` is asserted exactly `LONG_CYCLES` cycles after `press_pulse`.
- **Repeat timing:** successive `repeat_pulse` assertions are `REPEAT_CYCLES` apart; the first is `REPEAT_CYCLES` after `long_pulse`.
- **Shortest press:** a one-cycle `key_stable` high still yields `press_pulse` and then `release_pulse` one cycle later.
- **Handshake:** none. Consumers must sample the pulses every cycle.

## Configuration
- `KEY_AUTOREPEAT_EN` defined: LONG state generates periodic `repeat_pulse`.
- `KEY_AUTOREPEAT_EN` undefined:
  - `repeat_pulse` is tied to 0;
  - LONG waits only for release;
  - the repeat compare logic is removed.

## Structure
- **Shared package `key_pkg`:**
  - FSM state typedef `key_state_t` (IDLE, HOLD, LONG);
  - default timing constants `KEY_LONG_CYCLES_DEF` and `KEY_REPEAT_CYCLES_DEF`.
- **Sub-modules:** none required. A single module holds the FSM, counter, and edge register; the edge detector is too small to split out.

## Test plan
All scenarios use `LONG_CYCLES`=8 and `REPEAT_CYCLES`=4.
1. **Reset:** hold `rst_n`=0 with `key_stable`=1 → all outputs 0; release reset → `press_pulse` 1 cycle after the first sampled edge.
2. **Short press:** `key_stable` high for 3 cycles → `press_pulse` once, `held` high 3 cycles, `release_pulse` once, no `long_pulse`.
3. **Long press:** hold 20 cycles with `KEY_AUTOREPEAT_EN` → `long_pulse` 8 cycles after press, `repeat_pulse` at +12 and +16, `release_pulse` after the drop.
4. **Long press without macro:** same stimulus as scenario 3 → `long_pulse` at +8, `repeat_pulse` never asserted.
5. **Release at terminal count:** drop `key_stable` so the release edge lands on `cnt`=7 in HOLD → `release_pulse` only, no `long_pulse`.
6. **Reset mid-hold:** assert `rst_n`=0 during LONG → outputs 0 immediately; after reset with the key still held, a new `press_pulse` fires and `long_pulse` follows 8 cycles later.
